// File: rtl/data_mem_lsu_if.sv
// rtl/data_mem_lsu_if.sv - request, response and memory-port bundle for the data-memory LSU
interface data_mem_lsu_if #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 16
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [15:0]       req_base;
   logic [5:0]        req_off;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic              mem_wr_en;
   logic              mem_rd_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   // master is the LSU itself; slave is the execute stage plus memory around it
   modport master (
      input  req_valid, req_we, req_base, req_off, req_wdata, rsp_ready, mem_rdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_wr_en, mem_rd_en, mem_addr, mem_wdata
   );
   modport slave (
      output req_valid, req_we, req_base, req_off, req_wdata, rsp_ready, mem_rdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_wr_en, mem_rd_en, mem_addr, mem_wdata
   );
endinterface

// File: rtl/data_mem_lsu.sv
// rtl/data_mem_lsu.sv - single-outstanding load/store initiator for the 16-bit core's data memory
module data_mem_lsu #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 16
) (
   input  logic          i_clk,
   input  logic          i_rst,
   data_mem_lsu_if.master bus
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_CAPT  = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   logic [1:0]        r_state;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic              r_rsp_err;
   logic [DATA_W-1:0] r_rsp_rdata;

   logic [15:0]       w_ea;
   logic              w_err;
   logic              w_accept;

   assign w_ea     = bus.req_base + {{10{bus.req_off[5]}}, bus.req_off};
   assign w_err    = |w_ea[15:ADDR_W];
   assign w_accept = bus.req_valid & bus.req_ready;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= S_IDLE;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_rsp_err   <= 1'b0;
         r_rsp_rdata <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_we        <= bus.req_we;
                  r_addr      <= w_ea[ADDR_W-1:0];
                  r_wdata     <= bus.req_wdata;
                  r_rsp_err   <= w_err;
                  r_rsp_rdata <= '0;
                  r_state     <= w_err ? S_RESP : S_ISSUE;
               end
            end
            S_ISSUE: r_state <= r_we ? S_RESP : S_CAPT;
            S_CAPT: begin
               // memory output register was loaded on the edge that ended ISSUE
               r_rsp_rdata <= bus.mem_rdata;
               r_state     <= S_RESP;
            end
            S_RESP: begin
               if (bus.rsp_ready) begin
                  r_rsp_err   <= 1'b0;
                  r_rsp_rdata <= '0;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // memory port decodes only registered state, so req_* never reaches mem_* combinationally
   assign bus.req_ready = (r_state == S_IDLE) & ~i_rst;
   assign bus.rsp_valid = (r_state == S_RESP);
   assign bus.rsp_err   = r_rsp_err;
   assign bus.rsp_rdata = r_rsp_rdata;
   assign bus.mem_wr_en = (r_state == S_ISSUE) & r_we;
   assign bus.mem_rd_en = (r_state == S_ISSUE) & ~r_we;
   assign bus.mem_addr  = r_addr;
   assign bus.mem_wdata = r_wdata;
endmodule

// File: tb/tb_data_mem_lsu.sv
// tb/tb_data_mem_lsu.sv - scoreboard bench for data_mem_lsu with a registered-output memory model
module tb_data_mem_lsu;
   typedef struct {
      logic        err;
      logic [15:0] rdata;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_bad = 0;
   int   cyc = 0;
   int   n_en = 0;
   int   n_overlap = 0;
   int   acc_cyc = 0;
   exp_t q[$];
   logic [15:0] ref_mem [64];
   logic [15:0] mem [64];

   data_mem_lsu_if #(.ADDR_W(6), .DATA_W(16)) bus ();

   data_mem_lsu #(.ADDR_W(6), .DATA_W(16)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_wdata;
      if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];
      if (bus.mem_wr_en || bus.mem_rd_en) n_en <= n_en + 1;
      if (bus.mem_wr_en && bus.mem_rd_en) n_overlap <= n_overlap + 1;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // waits for req_ready, records the expected response, and leaves the bench in cycle 1
   task automatic accept(input logic we, input logic [15:0] base, input logic [5:0] off, input logic [15:0] wdata);
      logic [15:0] ea;
      exp_t        e;
      int          n;
      n = 0;
      while (!bus.req_ready && n < 20) begin step(); n++; end
      n_vec++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL accept_wait: req_ready=%b required 1", bus.req_ready); end
      ea = base + {{10{off[5]}}, off};
      e.err = |ea[15:6];
      e.rdata = (e.err || we) ? 16'h0 : ref_mem[ea[5:0]];
      if (!e.err && we) ref_mem[ea[5:0]] = wdata;
      q.push_back(e);
      bus.req_valid = 1'b1; bus.req_we = we; bus.req_base = base; bus.req_off = off; bus.req_wdata = wdata;
      step();
      bus.req_valid = 1'b0;
      acc_cyc = cyc;
   endtask

   task automatic get_rsp(output logic got, output logic err, output logic [15:0] rdata);
      got = 1'b0; err = 1'b0; rdata = 16'h0;
      for (int i = 0; i < 20; i++) begin
         if (bus.rsp_valid) begin
            got = 1'b1; err = bus.rsp_err; rdata = bus.rsp_rdata;
            bus.rsp_ready = 1'b1;
            step();
            bus.rsp_ready = 1'b0;
            break;
         end
         step();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_base = 16'h0001; bus.req_off = 6'd1; bus.req_wdata = 16'hFFFF;
      step(); step();
      n_vec++; if (bus.req_ready !== 1'b0) begin n_bad++; $display("FAIL reset_req_ready: %b required 0", bus.req_ready); end
      n_vec++; if (bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 16'h0) begin n_bad++; $display("FAIL reset_rsp: valid=%b err=%b rdata=%h required 0/0/0000", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata); end
      n_vec++; if (bus.mem_wr_en !== 1'b0 || bus.mem_rd_en !== 1'b0 || bus.mem_addr !== 6'd0 || bus.mem_wdata !== 16'h0) begin n_bad++; $display("FAIL reset_mem: wr=%b rd=%b addr=%h wdata=%h required all 0", bus.mem_wr_en, bus.mem_rd_en, bus.mem_addr, bus.mem_wdata); end
      bus.req_valid = 1'b0; rst = 1'b0; #1;
      n_vec++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_release_ready: %b required 1", bus.req_ready); end
   endtask

   task automatic test_store();
      logic got, err; logic [15:0] rd; exp_t e;
      accept(1'b1, 16'h0010, 6'd3, 16'hBEEF);
      n_vec++; if (bus.mem_wr_en !== 1'b1 || bus.mem_rd_en !== 1'b0) begin n_bad++; $display("FAIL store_c1_en: wr=%b rd=%b required 1/0", bus.mem_wr_en, bus.mem_rd_en); end
      n_vec++; if (bus.mem_addr !== 6'd19 || bus.mem_wdata !== 16'hBEEF) begin n_bad++; $display("FAIL store_c1_port: addr=%0d wdata=%h required 19/beef", bus.mem_addr, bus.mem_wdata); end
      n_vec++; if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL store_c1_rsp: rsp_valid=%b required 0", bus.rsp_valid); end
      step();
      n_vec++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0 || bus.mem_wr_en !== 1'b0) begin n_bad++; $display("FAIL store_c2: valid=%b err=%b wr=%b required 1/0/0", bus.rsp_valid, bus.rsp_err, bus.mem_wr_en); end
      get_rsp(got, err, rd); e = q.pop_front();
      n_vec++; if (got !== 1'b1 || err !== e.err || rd !== e.rdata) begin n_bad++; $display("FAIL store_rsp: got=%b err=%b rdata=%h required 1/%b/%h", got, err, rd, e.err, e.rdata); end
      n_vec++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL store_idle: req_ready=%b required 1", bus.req_ready); end
   endtask

   task automatic test_load();
      logic got, err; logic [15:0] rd; exp_t e;
      accept(1'b0, 16'h0010, 6'd3, 16'h0);
      n_vec++; if (bus.mem_rd_en !== 1'b1 || bus.mem_wr_en !== 1'b0 || bus.mem_addr !== 6'd19) begin n_bad++; $display("FAIL load_c1: rd=%b wr=%b addr=%0d required 1/0/19", bus.mem_rd_en, bus.mem_wr_en, bus.mem_addr); end
      step();
      n_vec++; if (bus.rsp_valid !== 1'b0 || bus.mem_rd_en !== 1'b0) begin n_bad++; $display("FAIL load_c2: valid=%b rd=%b required 0/0", bus.rsp_valid, bus.mem_rd_en); end
      step();
      n_vec++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 16'hBEEF) begin n_bad++; $display("FAIL load_c3: valid=%b rdata=%h required 1/beef", bus.rsp_valid, bus.rsp_rdata); end
      get_rsp(got, err, rd); e = q.pop_front();
      n_vec++; if (got !== 1'b1 || err !== e.err || rd !== e.rdata) begin n_bad++; $display("FAIL load_rsp: got=%b err=%b rdata=%h required 1/%b/%h", got, err, rd, e.err, e.rdata); end
   endtask

   task automatic test_error();
      logic got, err; logic [15:0] rd; exp_t e; int en0;
      logic [15:0] bases [2] = '{16'h0040, 16'h0000};
      logic [5:0]  offs  [2] = '{6'd0, 6'h3F};
      en0 = n_en;
      for (int i = 0; i < 2; i++) begin
         accept(1'b0, bases[i], offs[i], 16'h0);
         n_vec++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.rsp_rdata !== 16'h0) begin n_bad++; $display("FAIL err_c1_%0d: valid=%b err=%b rdata=%h required 1/1/0000", i, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata); end
         get_rsp(got, err, rd); e = q.pop_front();
         n_vec++; if (got !== 1'b1 || err !== e.err || rd !== e.rdata) begin n_bad++; $display("FAIL err_rsp_%0d: got=%b err=%b rdata=%h required 1/%b/%h", i, got, err, rd, e.err, e.rdata); end
      end
      n_vec++; if (n_en !== en0) begin n_bad++; $display("FAIL err_no_access: enable cycles=%0d required %0d", n_en - en0, 0); end
   endtask

   task automatic test_backpressure();
      logic got, err; logic [15:0] rd; exp_t e; int en0;
      accept(1'b1, 16'h003F, 6'd0, 16'hA5C3);
      get_rsp(got, err, rd); e = q.pop_front();
      n_vec++; if (got !== 1'b1 || err !== e.err || rd !== e.rdata) begin n_bad++; $display("FAIL bp_store_rsp: got=%b err=%b rdata=%h required 1/%b/%h", got, err, rd, e.err, e.rdata); end
      accept(1'b0, 16'h003F, 6'd0, 16'h0);
      step(); step();
      en0 = n_en;
      // a competing store is offered throughout and must be ignored
      bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_base = 16'h0000; bus.req_off = 6'd0; bus.req_wdata = 16'hDEAD;
      for (int i = 0; i < 5; i++) begin
         n_vec++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== q[0].rdata || bus.req_ready !== 1'b0) begin n_bad++; $display("FAIL bp_hold_%0d: valid=%b rdata=%h ready=%b required 1/%h/0", i, bus.rsp_valid, bus.rsp_rdata, bus.req_ready, q[0].rdata); end
         step();
      end
      bus.req_valid = 1'b0;
      get_rsp(got, err, rd); e = q.pop_front();
      n_vec++; if (got !== 1'b1 || err !== e.err || rd !== e.rdata) begin n_bad++; $display("FAIL bp_rsp: got=%b err=%b rdata=%h required 1/%b/%h", got, err, rd, e.err, e.rdata); end
      n_vec++; if (bus.req_ready !== 1'b1 || n_en !== en0) begin n_bad++; $display("FAIL bp_idle: ready=%b stray_en=%0d required 1/0", bus.req_ready, n_en - en0); end
   endtask

   task automatic test_back_to_back();
      logic got, err; logic [15:0] rd; exp_t e; int acc [3];
      logic        wes   [3] = '{1'b1, 1'b0, 1'b1};
      logic [15:0] bases [3] = '{16'h0008, 16'h0008, 16'h0030};
      logic [5:0]  offs  [3] = '{6'd2, 6'd2, 6'h30};
      logic [15:0] wds   [3] = '{16'h5A5A, 16'h0000, 16'h0C3C};
      for (int i = 0; i < 3; i++) begin
         accept(wes[i], bases[i], offs[i], wds[i]);
         acc[i] = acc_cyc;
         get_rsp(got, err, rd); e = q.pop_front();
         n_vec++; if (got !== 1'b1 || err !== e.err || rd !== e.rdata) begin n_bad++; $display("FAIL b2b_rsp_%0d: got=%b err=%b rdata=%h required 1/%b/%h", i, got, err, rd, e.err, e.rdata); end
      end
      n_vec++; if (acc[1] - acc[0] !== 3 || acc[2] - acc[0] !== 7) begin n_bad++; $display("FAIL b2b_accept_cycles: %0d,%0d required 3,7", acc[1] - acc[0], acc[2] - acc[0]); end
      n_vec++; if (mem[32] !== 16'h0C3C) begin n_bad++; $display("FAIL b2b_mem32: %h required 0c3c", mem[32]); end
   endtask

   task automatic test_ea_bounds();
      logic got, err; logic [15:0] rd; exp_t e;
      logic        wes   [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [15:0] bases [8] = '{16'hFFFF, 16'h005F, 16'hFFFF, 16'h0041, 16'h003F, 16'h0000, 16'h7FFF, 16'h0020};
      logic [5:0]  offs  [8] = '{6'd1, 6'h20, 6'd1, 6'h3E, 6'd1, 6'h3F, 6'd1, 6'h20};
      logic [15:0] wds   [8] = '{16'h1111, 16'h2222, 16'h0, 16'h0, 16'h0, 16'h9999, 16'h0, 16'h0};
      for (int i = 0; i < 8; i++) begin
         accept(wes[i], bases[i], offs[i], wds[i]);
         get_rsp(got, err, rd); e = q.pop_front();
         n_vec++; if (got !== 1'b1 || err !== e.err || rd !== e.rdata) begin n_bad++; $display("FAIL ea_%0d: got=%b err=%b rdata=%h required 1/%b/%h", i, got, err, rd, e.err, e.rdata); end
      end
   endtask

   task automatic test_reset_mid();
      logic got, err; logic [15:0] rd; exp_t e; int nv;
      accept(1'b0, 16'h0010, 6'd3, 16'h0);
      rst = 1'b1;
      step();
      e = q.pop_back();
      n_vec++; if (bus.mem_rd_en !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b0) begin n_bad++; $display("FAIL rstmid_edge: rd=%b valid=%b ready=%b required 0/0/0", bus.mem_rd_en, bus.rsp_valid, bus.req_ready); end
      rst = 1'b0; #1;
      n_vec++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_ready: %b required 1", bus.req_ready); end
      nv = 0;
      for (int i = 0; i < 4; i++) begin if (bus.rsp_valid) nv++; step(); end
      n_vec++; if (nv !== 0) begin n_bad++; $display("FAIL rstmid_no_rsp: rsp_valid cycles=%0d required 0", nv); end
      // store already past ISSUE when reset hits: memory keeps the write
      accept(1'b1, 16'h0000, 6'd5, 16'h7E57);
      step();
      rst = 1'b1; step(); rst = 1'b0;
      e = q.pop_back();
      accept(1'b0, 16'h0005, 6'd0, 16'h0);
      get_rsp(got, err, rd); e = q.pop_front();
      n_vec++; if (got !== 1'b1 || err !== e.err || rd !== e.rdata) begin n_bad++; $display("FAIL rstmid_store_kept: got=%b err=%b rdata=%h required 1/%b/%h", got, err, rd, e.err, e.rdata); end
   endtask

   initial begin
      bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_base = 16'h0; bus.req_off = 6'd0;
      bus.req_wdata = 16'h0; bus.rsp_ready = 1'b0;
      test_reset();
      test_store();
      test_load();
      test_error();
      test_backpressure();
      test_back_to_back();
      test_ea_bounds();
      test_reset_mid();
      n_vec++; if (n_overlap !== 0) begin n_bad++; $display("FAIL enable_overlap: %0d cycles required 0", n_overlap); end
      n_vec++; if (q.size() !== 0) begin n_bad++; $display("FAIL scoreboard_left: %0d entries required 0", q.size()); end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
      $fatal(1, "watchdog");
   end
endmodule
